// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: forms the RISC-V immediate for the selected format
// and buffers it with its tag in a 2-entry FIFO. Optional macro: IMM_AUTODECODE_EN.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [2:0]      in_immsrc,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic [TAGW-1:0] out_tag
);

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_J   = 3'd3,
    FMT_U   = 3'd4,
    FMT_Z   = 3'd5,
    FMT_BAD = 3'd7
  } fmt_e;

  fmt_e            fmt;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            imm_illegal;

`ifdef IMM_AUTODECODE_EN
  logic unused_immsrc;
  assign unused_immsrc = ^in_immsrc;

  always_comb begin
    fmt = FMT_BAD;
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
      7'b0100011:                         fmt = FMT_S;
      7'b1100011:                         fmt = FMT_B;
      7'b1101111:                         fmt = FMT_J;
      7'b0110111, 7'b0010111:             fmt = FMT_U;
      7'b1110011:                         fmt = in_instr[14] ? FMT_Z : FMT_I;
      default:                            fmt = FMT_BAD;
    endcase
  end
`else
  logic unused_instr;
  assign unused_instr = ^in_instr[6:0];

  always_comb begin
    fmt = FMT_BAD;
    case (in_immsrc)
      3'b000:  fmt = FMT_I;
      3'b001:  fmt = FMT_S;
      3'b010:  fmt = FMT_B;
      3'b011:  fmt = FMT_J;
      3'b100:  fmt = FMT_U;
      3'b101:  fmt = FMT_Z;
      default: fmt = FMT_BAD;
    endcase
  end
`endif

  // imm32 is already sign-extended to 32 bits; bit 31 then fills the upper XLEN bits
  // (Z keeps bit 31 clear, so the same fill gives zero extension).
  always_comb begin
    imm32       = '0;
    imm_illegal = 1'b0;
    case (fmt)
      FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      FMT_U: imm32 = {in_instr[31:12], 12'b0};
      FMT_Z: imm32 = {27'b0, in_instr[19:15]};
      default: begin
        imm32       = '0;
        imm_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    imm_ext        = {XLEN{imm32[31]}};
    imm_ext[31:0]  = imm32;
  end

  logic [XLEN-1:0] mem_imm [2];
  logic            mem_ill [2];
  logic [TAGW-1:0] mem_tag [2];
  logic            wptr;
  logic            rptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_imm[i] <= '0;
        mem_ill[i] <= 1'b0;
        mem_tag[i] <= '0;
      end
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem_imm[wptr] <= imm_ext;
        mem_ill[wptr] <= imm_illegal;
        mem_tag[wptr] <= in_tag;
        wptr          <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_imm     = mem_imm[rptr];
  assign out_illegal = mem_ill[rptr];
  assign out_tag     = mem_tag[rptr];

endmodule
